miriscv_div: RTL and testbench

//  Sequential radix-2 integer divider for the MDU: DIV, DIVU, REM, REMU (RV32M).

---
 rtl/miriscv_div.sv | 155 +++++++++++++++
 tb/tb_miriscv_div.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_div.sv
// Sequential radix-2 non-restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the start/stall/kill/keep handshake of miriscv_mul; the MDU picks quotient or remainder.
module miriscv_div #(
  parameter DIV_IMPLEMENTATION = "GENERIC"
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        div_start_i,
  input  logic [31:0] port_a_i,
  input  logic [31:0] port_b_i,
  input  logic [2:0]  mdu_op_i,
  input  logic        zero_i,
  input  logic        kill_i,
  input  logic        keep_i,
  output logic [31:0] div_result_o,
  output logic [31:0] rem_result_o,
  output logic        div_stall_req_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MDU_DIV  = 3'd4;
  localparam logic [2:0] MDU_DIVU = 3'd5;
  localparam logic [2:0] MDU_REM  = 3'd6;
  localparam logic [2:0] MDU_REMU = 3'd7;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] FIRST       = 3'd1;
  localparam logic [2:0] COMP        = 3'd2;
  localparam logic [2:0] LAST        = 3'd3;
  localparam logic [2:0] SIGN_CHANGE = 3'd4;
  localparam logic [2:0] FINISH      = 3'd5;

  if (DIV_IMPLEMENTATION != "GENERIC") begin : g_bad_impl
    $error("miriscv_div: unsupported DIV_IMPLEMENTATION");
  end

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN:0]   prem_q, prem_d;   // signed partial remainder, one guard bit
  logic [XLEN-1:0] a_q, a_d;         // dividend magnitude, shifted out MSB first
  logic [XLEN-1:0] b_q, b_d;
  logic            sign_quot_q, sign_quot_d;
  logic            sign_rem_q, sign_rem_d;
  logic [4:0]      iter_q, iter_d;

  logic            op_signed;
  logic [XLEN:0]   prem_shift;
  logic [XLEN:0]   prem_step;

  // MDU_DIVU, MDU_REMU and any unknown code take the unsigned path.
  assign op_signed = (mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM);

  // Modular 33-bit arithmetic is exact here: every step result lies in [-B, B).
  assign prem_shift = {prem_q[XLEN-1:0], a_q[XLEN-1]};
  assign prem_step  = prem_q[XLEN] ? prem_shift + {1'b0, b_q} : prem_shift - {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    quot_d      = quot_q;
    prem_d      = prem_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_quot_d = sign_quot_q;
    sign_rem_d  = sign_rem_q;
    iter_d      = iter_q;

    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_start_i) begin
            state_d     = FIRST;
            a_d         = (op_signed && port_a_i[XLEN-1]) ? -port_a_i : port_a_i;
            b_d         = (op_signed && port_b_i[XLEN-1]) ? -port_b_i : port_b_i;
            sign_quot_d = op_signed && (port_a_i[XLEN-1] ^ port_b_i[XLEN-1]);
            sign_rem_d  = op_signed && port_a_i[XLEN-1];
          end
        end
        FIRST: begin
          if (zero_i) begin
            state_d = FINISH;
            quot_d  = '1;
            prem_d  = {1'b0, port_a_i};
          end else begin
            state_d = COMP;
            iter_d  = 5'd31;
            quot_d  = '0;
            prem_d  = {{XLEN{1'b0}}, a_q[XLEN-1]} - {1'b0, b_q};
            a_d     = a_q << 1;
          end
        end
        COMP: begin
          quot_d[iter_q] = ~prem_q[XLEN];
          prem_d         = prem_step;
          a_d            = a_q << 1;
          iter_d         = iter_q - 5'd1;
          if (iter_q == 5'd1) begin
            state_d = LAST;
          end
        end
        LAST: begin
          quot_d[0] = ~prem_q[XLEN];
          if (prem_q[XLEN]) begin
            prem_d = prem_q + {1'b0, b_q};
          end
          state_d = (sign_quot_q || sign_rem_q) ? SIGN_CHANGE : FINISH;
        end
        SIGN_CHANGE: begin
          if (sign_quot_q) begin
            quot_d = -quot_q;
          end
          if (sign_rem_q) begin
            prem_d = {1'b0, -prem_q[XLEN-1:0]};
          end
          state_d = FINISH;
        end
        FINISH: begin
          if (!keep_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      quot_q      <= '0;
      prem_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
      iter_q      <= '0;
    end else begin
      state_q     <= state_d;
      quot_q      <= quot_d;
      prem_q      <= prem_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_quot_q <= sign_quot_d;
      sign_rem_q  <= sign_rem_d;
      iter_q      <= iter_d;
    end
  end

  assign div_result_o    = quot_q;
  assign rem_result_o    = prem_q[XLEN-1:0];
  assign div_stall_req_o = div_start_i && (state_q != FINISH);

endmodule

// File: tb/tb_miriscv_div.sv
// Self-checking bench for miriscv_div: directed RV32M cases plus a random sweep
// against an arithmetic reference model.
module tb_miriscv_div;

  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_DIVU = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        arst;
  logic        div_start;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [2:0]  mdu_op;
  logic        zero;
  logic        kill;
  logic        keep;
  logic [31:0] div_result;
  logic [31:0] rem_result;
  logic        div_stall_req;

  int checks = 0;
  int errors = 0;

  miriscv_div #(
    .DIV_IMPLEMENTATION("GENERIC")
  ) dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .div_start_i    (div_start),
    .port_a_i       (port_a),
    .port_b_i       (port_b),
    .mdu_op_i       (mdu_op),
    .zero_i         (zero),
    .kill_i         (kill),
    .keep_i         (keep),
    .div_result_o   (div_result),
    .rem_result_o   (rem_result),
    .div_stall_req_o(div_stall_req)
  );

  always #5 clk = ~clk;

  // Reference: RV32M results and stall length from plain arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, output logic [31:0] q,
                                output logic [31:0] r, output int cyc);
    bit     sgn;
    longint sa;
    longint sb;
    sgn = (op == OP_DIV) || (op == OP_REM);
    sa  = $signed(a);
    sb  = $signed(b);
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      cyc = 2;
    end else if (sgn) begin
      q   = 32'(sa / sb);
      r   = 32'(sa % sb);
      cyc = 34 + ((a[31] || b[31]) ? 1 : 0);
    end else begin
      q   = a / b;
      r   = a % b;
      cyc = 34;
    end
  endfunction

  // Drives one request and counts stall cycles; start is released once stall drops
  // unless hold_start is set. A runaway stall returns cyc = 201.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input bit hold_start, output logic [31:0] q, output logic [31:0] r,
                        output int cyc);
    @(negedge clk);
    port_a    = a;
    port_b    = b;
    mdu_op    = op;
    zero      = (b == 32'd0);
    div_start = 1'b1;
    cyc       = 0;
    #2;
    while (div_stall_req) begin
      cyc++;
      if (cyc > 200) break;
      @(negedge clk);
      #2;
    end
    q = div_result;
    r = rem_result;
    if (!hold_start) div_start = 1'b0;
  endtask

  task automatic test_reset();
    arst      = 1'b1;
    div_start = 1'b0;
    kill      = 1'b0;
    keep      = 1'b0;
    port_a    = '0;
    port_b    = '0;
    mdu_op    = OP_DIVU;
    zero      = 1'b0;
    #12;
    checks++;
    if (div_result !== 32'd0) begin
      $display("FAIL reset_q: got %h want 00000000", div_result); errors++;
    end
    checks++;
    if (rem_result !== 32'd0) begin
      $display("FAIL reset_r: got %h want 00000000", rem_result); errors++;
    end
    checks++;
    if (div_stall_req !== 1'b0) begin
      $display("FAIL reset_stall: got %b want 0", div_stall_req); errors++;
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_divu_basic();
    logic [31:0] q, r;
    int          cyc;
    run_op(32'd100, 32'd7, OP_DIVU, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'd14) begin $display("FAIL divu_q: got %0d want 14", q); errors++; end
    checks++;
    if (r !== 32'd2) begin $display("FAIL divu_r: got %0d want 2", r); errors++; end
    checks++;
    if (cyc != 34) begin $display("FAIL divu_stall: got %0d want 34", cyc); errors++; end
  endtask

  task automatic test_signed_neg();
    logic [31:0] q, r;
    int          cyc;
    run_op(-32'sd7, 32'd2, OP_DIV, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'hFFFF_FFFD) begin $display("FAIL div_neg_q: got %h want fffffffd", q); errors++; end
    checks++;
    if (r !== 32'hFFFF_FFFF) begin $display("FAIL div_neg_r: got %h want ffffffff", r); errors++; end
    checks++;
    if (cyc != 35) begin $display("FAIL div_neg_stall: got %0d want 35", cyc); errors++; end
    run_op(-32'sd7, 32'd2, OP_REM, 1'b0, q, r, cyc);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin $display("FAIL rem_neg_r: got %h want ffffffff", r); errors++; end
    checks++;
    if (cyc != 35) begin $display("FAIL rem_neg_stall: got %0d want 35", cyc); errors++; end
  endtask

  task automatic test_zero_div();
    logic [31:0] q, r;
    int          cyc;
    run_op(32'd5, 32'd0, OP_DIVU, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'hFFFF_FFFF) begin $display("FAIL divu0_q: got %h want ffffffff", q); errors++; end
    checks++;
    if (r !== 32'd5) begin $display("FAIL divu0_r: got %h want 00000005", r); errors++; end
    checks++;
    if (cyc != 2) begin $display("FAIL divu0_stall: got %0d want 2", cyc); errors++; end
    run_op(-32'sd5, 32'd0, OP_DIV, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'hFFFF_FFFF) begin $display("FAIL div0_q: got %h want ffffffff", q); errors++; end
    checks++;
    if (r !== 32'hFFFF_FFFB) begin $display("FAIL div0_r: got %h want fffffffb", r); errors++; end
    checks++;
    if (cyc != 2) begin $display("FAIL div0_stall: got %0d want 2", cyc); errors++; end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r;
    int          cyc;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'h8000_0000) begin $display("FAIL ovf_q: got %h want 80000000", q); errors++; end
    checks++;
    if (r !== 32'd0) begin $display("FAIL ovf_r: got %h want 00000000", r); errors++; end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic [2:0]  op;
    int          cyc, ecyc;
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 100);
        3:       b = -32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      if (i < 4) op = OP_DIV + 3'(i);
      model(a, b, op, eq, er, ecyc);
      run_op(a, b, op, 1'b0, q, r, cyc);
      checks++;
      if (q !== eq || r !== er || cyc != ecyc) begin
        $display("FAIL rand_%0d op=%0d a=%h b=%h: got q=%h r=%h cyc=%0d want q=%h r=%h cyc=%0d",
                 i, op, a, b, q, r, cyc, eq, er, ecyc);
        errors++;
      end
    end
  endtask

  task automatic test_kill();
    logic [31:0] q, r;
    int          cyc;
    @(negedge clk);
    port_a    = 32'd1000;
    port_b    = 32'd3;
    mdu_op    = OP_DIVU;
    zero      = 1'b0;
    div_start = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #2;
    kill      = 1'b1;
    div_start = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    run_op(32'd9, 32'd3, OP_DIVU, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'd3) begin $display("FAIL kill_restart_q: got %0d want 3", q); errors++; end
    checks++;
    if (r !== 32'd0) begin $display("FAIL kill_restart_r: got %0d want 0", r); errors++; end
    checks++;
    if (cyc != 34) begin $display("FAIL kill_restart_stall: got %0d want 34", cyc); errors++; end
  endtask

  task automatic test_async_reset();
    logic [31:0] q, r;
    int          cyc;
    @(negedge clk);
    port_a    = 32'hFFFF_FFF0;
    port_b    = 32'd1;
    mdu_op    = OP_DIVU;
    zero      = 1'b0;
    div_start = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    checks++;
    if (div_result !== 32'd0) begin
      $display("FAIL arst_q: got %h want 00000000", div_result); errors++;
    end
    checks++;
    if (rem_result !== 32'd0) begin
      $display("FAIL arst_r: got %h want 00000000", rem_result); errors++;
    end
    div_start = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    run_op(32'd100, 32'd7, OP_DIVU, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || cyc != 34) begin
      $display("FAIL arst_restart: got q=%0d r=%0d cyc=%0d want q=14 r=2 cyc=34", q, r, cyc);
      errors++;
    end
  endtask

  task automatic test_keep();
    logic [31:0] q, r;
    int          cyc;
    run_op(32'd100, 32'd7, OP_DIVU, 1'b1, q, r, cyc);
    keep = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      checks++;
      if (div_stall_req !== 1'b0 || div_result !== 32'd14 || rem_result !== 32'd2) begin
        $display("FAIL keep_hold_%0d: got stall=%b q=%0d r=%0d want stall=0 q=14 r=2",
                 i, div_stall_req, div_result, rem_result);
        errors++;
      end
    end
    keep      = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    #2;
    checks++;
    if (div_result !== 32'd14 || rem_result !== 32'd2) begin
      $display("FAIL keep_idle_hold: got q=%0d r=%0d want q=14 r=2", div_result, rem_result);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    int          cyc;
    run_op(32'd81, 32'd9, OP_REMU, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'd9 || r !== 32'd0 || cyc != 34) begin
      $display("FAIL b2b_first: got q=%0d r=%0d cyc=%0d want q=9 r=0 cyc=34", q, r, cyc);
      errors++;
    end
    run_op(32'd50, -32'sd8, OP_DIV, 1'b0, q, r, cyc);
    checks++;
    if (q !== 32'hFFFF_FFFA || r !== 32'd2 || cyc != 35) begin
      $display("FAIL b2b_second: got q=%h r=%h cyc=%0d want q=fffffffa r=00000002 cyc=35",
               q, r, cyc);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed_neg();
    test_zero_div();
    test_overflow();
    test_kill();
    test_async_reset();
    test_keep();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
